// File: rtl/stepmotor_seq_ctrl_if.sv
// Control/status bundle between the board control logic and the stepper sequencer.
// Latency: wires only, no storage.
// Backpressure: none; start/stop are single-cycle requests, status is level/pulse.
//
// Ports (master = board logic, slave = sequencer):
//   start, stop, en, dir, mode[1:0], period[DIV_W-1:0], steps[CNT_W-1:0]  master -> slave
//   stepmotor[3:0], state[1:0], phase[2:0], busy, done, step_cnt[CNT_W-1:0]  slave -> master
interface stepmotor_seq_ctrl_if #(
  parameter int DIV_W = 16,
  parameter int CNT_W = 12
);
  logic             start;
  logic             stop;
  logic             en;
  logic             dir;
  logic [1:0]       mode;
  logic [DIV_W-1:0] period;
  logic [CNT_W-1:0] steps;

  logic [3:0]       stepmotor;
  logic [1:0]       state;
  logic [2:0]       phase;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] step_cnt;

  modport master (
    output start, stop, en, dir, mode, period, steps,
    input  stepmotor, state, phase, busy, done, step_cnt
  );

  modport slave (
    input  start, stop, en, dir, mode, period, steps,
    output stepmotor, state, phase, busy, done, step_cnt
  );
endinterface

// File: rtl/stepmotor_seq_ctrl.sv
// 4-coil stepper sequencer: wave/full/half-step, direction, programmable rate, counted or continuous moves.
// Latency: start -> RUN next edge; first step period+1 cycles after the start edge; all outputs registered.
// Backpressure: en=0 freezes prescaler/phase/count; stop aborts a run next edge; start ignored outside IDLE.
//
// Ports: clk (rising edge), rst (synchronous, active-low), ctl (slave side of stepmotor_seq_ctrl_if:
// start/stop/en/dir/mode/period/steps in, stepmotor/state/phase/busy/done/step_cnt out).
module stepmotor_seq_ctrl #(
  parameter int DIV_W   = 16,
  parameter int CNT_W   = 12,
  parameter bit HOLD_EN = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  stepmotor_seq_ctrl_if.slave ctl
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t           state_r;
  logic [2:0]       phase_r;
  logic [3:0]       coil_r;
  logic             busy_r;
  logic             done_r;
  logic [CNT_W-1:0] step_cnt_r;
  logic [DIV_W-1:0] presc_r;
  logic [1:0]       mode_r;
  logic [DIV_W-1:0] period_r;
  logic             cont_r;     // latched steps==0: continuous rotation

  // Coil pattern {A,B,C,D}: even indices single coil, odd indices two adjacent coils.
  function automatic logic [3:0] coil_pat(input logic [2:0] idx);
    logic [3:0] p;
    case (idx)
      3'd0:    p = 4'b1000;
      3'd1:    p = 4'b1100;
      3'd2:    p = 4'b0100;
      3'd3:    p = 4'b0110;
      3'd4:    p = 4'b0010;
      3'd5:    p = 4'b0011;
      3'd6:    p = 4'b0001;
      default: p = 4'b1001;
    endcase
    return p;
  endfunction

  // Snap the phase onto the index subset the new mode walks (even for wave, odd for full).
  function automatic logic [2:0] align_phase(input logic [1:0] md, input logic [2:0] ph);
    logic [2:0] a;
    case (md)
      2'b00:   a = ph & 3'b110;
      2'b01:   a = ph | 3'b001;
      default: a = ph;          // half-step, and reserved 11 behaves as half-step
    endcase
    return a;
  endfunction

  logic [2:0] stride;
  logic [2:0] phase_nxt;
  logic [2:0] start_phase;
  logic       step_now;

  // mode[1] set means half-step (10 or 11): move one index, otherwise two; 3-bit wrap gives mod 8.
  assign stride      = mode_r[1] ? 3'd1 : 3'd2;
  assign phase_nxt   = ctl.dir ? (phase_r + stride) : (phase_r - stride);
  assign start_phase = align_phase(ctl.mode, phase_r);
  assign step_now    = ctl.en && (presc_r == period_r);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      phase_r    <= 3'd0;
      coil_r     <= 4'b0000;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      step_cnt_r <= '0;
      presc_r    <= '0;
      mode_r     <= 2'b00;
      period_r   <= '0;
      cont_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (ctl.start) begin
            // start wins over a coincident stop; stop has no meaning in IDLE
            state_r    <= ST_RUN;
            busy_r     <= 1'b1;
            mode_r     <= ctl.mode;
            period_r   <= ctl.period;
            cont_r     <= (ctl.steps == '0);
            step_cnt_r <= ctl.steps;   // zero for continuous, so it counts up from 0
            presc_r    <= '0;
            phase_r    <= start_phase;
            coil_r     <= coil_pat(start_phase);
          end else begin
            coil_r <= HOLD_EN ? coil_pat(phase_r) : 4'b0000;
          end
        end

        ST_RUN: begin
          if (ctl.stop) begin
            // abort beats a step due on this same edge
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            coil_r  <= HOLD_EN ? coil_pat(phase_r) : 4'b0000;
          end else if (step_now) begin
            presc_r <= '0;
            phase_r <= phase_nxt;
            coil_r  <= coil_pat(phase_nxt);
            if (cont_r) begin
              step_cnt_r <= step_cnt_r + CNT_W'(1);
            end else begin
              step_cnt_r <= step_cnt_r - CNT_W'(1);
              if (step_cnt_r == CNT_W'(1)) begin
                state_r <= ST_DONE;
                busy_r  <= 1'b0;
                done_r  <= 1'b1;
              end
            end
          end else if (ctl.en) begin
            presc_r <= presc_r + DIV_W'(1);
          end
        end

        ST_DONE: begin
          // pattern stays table[phase] through DONE; idle policy applies from the next cycle
          state_r <= ST_IDLE;
          coil_r  <= HOLD_EN ? coil_pat(phase_r) : 4'b0000;
        end

        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign ctl.stepmotor = coil_r;
  assign ctl.state     = state_r;
  assign ctl.phase     = phase_r;
  assign ctl.busy      = busy_r;
  assign ctl.done      = done_r;
  assign ctl.step_cnt  = step_cnt_r;

endmodule

// File: tb/tb_stepmotor_seq_ctrl.sv
// Directed bench for stepmotor_seq_ctrl: one holding-torque instance and one de-energising instance
// driven by the same stimulus, checked against hand-computed coil/phase/count sequences.
// Ports: none; clock and all control inputs generated here.
module tb_stepmotor_seq_ctrl;
  localparam int DIV_W = 16;
  localparam int CNT_W = 12;

  logic             clk;
  logic             rst;
  logic             start, stop, en, dir;
  logic [1:0]       mode;
  logic [DIV_W-1:0] period;
  logic [CNT_W-1:0] steps;

  int n_cmp;
  int n_err;

  stepmotor_seq_ctrl_if #(.DIV_W(DIV_W), .CNT_W(CNT_W)) if0 ();
  stepmotor_seq_ctrl_if #(.DIV_W(DIV_W), .CNT_W(CNT_W)) if1 ();

  assign if0.start = start;  assign if1.start = start;
  assign if0.stop  = stop;   assign if1.stop  = stop;
  assign if0.en    = en;     assign if1.en    = en;
  assign if0.dir   = dir;    assign if1.dir   = dir;
  assign if0.mode  = mode;   assign if1.mode  = mode;
  assign if0.period = period; assign if1.period = period;
  assign if0.steps = steps;  assign if1.steps = steps;

  stepmotor_seq_ctrl #(.DIV_W(DIV_W), .CNT_W(CNT_W), .HOLD_EN(1'b1)) u_hold (
    .clk (clk),
    .rst (rst),
    .ctl (if0.slave)
  );

  stepmotor_seq_ctrl #(.DIV_W(DIV_W), .CNT_W(CNT_W), .HOLD_EN(1'b0)) u_nohold (
    .clk (clk),
    .rst (rst),
    .ctl (if1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] hs_pat [4];
  logic [3:0] prev;

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b0; start = 1'b0; stop = 1'b0; en = 1'b1; dir = 1'b1;
    mode = 2'b00; period = '0; steps = '0;
    hs_pat = '{4'b1100, 4'b0100, 4'b0110, 4'b0010};

    // ---- reset state
    tick(); tick();
    check("rst_state", 32'(if0.state), 32'd0);
    check("rst_coil",  32'(if0.stepmotor), 32'h0);
    check("rst_phase", 32'(if0.phase), 32'd0);
    check("rst_busy",  32'(if0.busy), 32'd0);
    check("rst_done",  32'(if0.done), 32'd0);
    check("rst_cnt",   32'(if0.step_cnt), 32'd0);
    rst = 1'b1;
    tick();

    // ---- half-step CW, period=1, 4 steps
    mode = 2'b10; dir = 1'b1; period = 16'd1; steps = 12'd4; start = 1'b1;
    tick(); start = 1'b0;
    check("hs_state", 32'(if0.state), 32'd1);
    check("hs_busy",  32'(if0.busy), 32'd1);
    check("hs_cnt0",  32'(if0.step_cnt), 32'd4);
    check("hs_coil0", 32'(if0.stepmotor), 32'h8);
    prev = 4'b1000;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("hs_hold", 32'(if0.stepmotor), 32'(prev));
      tick();
      check("hs_coil", 32'(if0.stepmotor), 32'(hs_pat[k]));
      prev = hs_pat[k];
    end
    check("hs_done",   32'(if0.done), 32'd1);
    check("hs_dstate", 32'(if0.state), 32'd2);
    check("hs_dbusy",  32'(if0.busy), 32'd0);
    check("hs_phase",  32'(if0.phase), 32'd4);
    check("hs_cnt",    32'(if0.step_cnt), 32'd0);
    tick();
    check("hs_idle",   32'(if0.state), 32'd0);
    check("hs_done1",  32'(if0.done), 32'd0);
    check("hs_held",   32'(if0.stepmotor), 32'h2);

    // ---- one half-step CCW to reach phase 3
    mode = 2'b10; dir = 1'b0; period = 16'd0; steps = 12'd1; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick();
    check("pre_phase", 32'(if0.phase), 32'd3);

    // ---- wave CCW with alignment 3 -> 2
    mode = 2'b00; dir = 1'b0; period = 16'd0; steps = 12'd3; start = 1'b1;
    tick(); start = 1'b0;
    check("wv_align", 32'(if0.phase), 32'd2);
    check("wv_coil0", 32'(if0.stepmotor), 32'h4);
    tick();
    check("wv_coil1", 32'(if0.stepmotor), 32'h8);
    check("wv_cnt1",  32'(if0.step_cnt), 32'd2);
    tick();
    check("wv_coil2", 32'(if0.stepmotor), 32'h1);
    check("wv_ph2",   32'(if0.phase), 32'd6);
    tick();
    check("wv_coil3", 32'(if0.stepmotor), 32'h2);
    check("wv_ph3",   32'(if0.phase), 32'd4);
    check("wv_done",  32'(if0.done), 32'd1);
    tick();

    // ---- full-step continuous, live reversal, stop
    rst = 1'b0; tick(); rst = 1'b1; tick();
    mode = 2'b01; dir = 1'b1; period = 16'd2; steps = 12'd0; start = 1'b1;
    tick(); start = 1'b0;
    check("fs_align", 32'(if0.phase), 32'd1);
    check("fs_coil0", 32'(if0.stepmotor), 32'hC);
    repeat (3) tick();
    check("fs_coil1", 32'(if0.stepmotor), 32'h6);
    repeat (3) tick();
    check("fs_coil2", 32'(if0.stepmotor), 32'h3);
    check("fs_cnt2",  32'(if0.step_cnt), 32'd2);
    dir = 1'b0;
    repeat (3) tick();
    check("fs_rev1",  32'(if0.stepmotor), 32'h6);
    repeat (3) tick();
    check("fs_rev2",  32'(if0.stepmotor), 32'hC);
    repeat (3) tick();
    check("fs_wrap",  32'(if0.phase), 32'd7);
    check("fs_rev3",  32'(if0.stepmotor), 32'h9);
    stop = 1'b1;
    tick(); stop = 1'b0;
    check("fs_stop",  32'(if0.state), 32'd0);
    check("fs_sbusy", 32'(if0.busy), 32'd0);
    check("fs_sdone", 32'(if0.done), 32'd0);
    check("fs_sph",   32'(if0.phase), 32'd7);
    check("fs_scnt",  32'(if0.step_cnt), 32'd5);

    // ---- pause mid counted move
    mode = 2'b10; dir = 1'b1; period = 16'd1; steps = 12'd3; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick();
    check("pz_ph1",  32'(if0.phase), 32'd0);
    check("pz_cnt1", 32'(if0.step_cnt), 32'd2);
    tick();
    en = 1'b0;
    repeat (10) tick();
    check("pz_fph",   32'(if0.phase), 32'd0);
    check("pz_fcnt",  32'(if0.step_cnt), 32'd2);
    check("pz_fcoil", 32'(if0.stepmotor), 32'h8);
    check("pz_fst",   32'(if0.state), 32'd1);
    en = 1'b1;
    tick();
    check("pz_ph2",  32'(if0.phase), 32'd1);
    check("pz_cnt2", 32'(if0.step_cnt), 32'd1);
    tick(); tick();
    check("pz_ph3",  32'(if0.phase), 32'd2);
    check("pz_done", 32'(if0.done), 32'd1);
    tick();

    // ---- reset in the middle of a move
    mode = 2'b10; dir = 1'b1; period = 16'd0; steps = 12'd8; start = 1'b1;
    tick(); start = 1'b0;
    repeat (3) tick();
    check("rm_cnt", 32'(if0.step_cnt), 32'd5);
    rst = 1'b0; start = 1'b1;
    tick();
    check("rm_state", 32'(if0.state), 32'd0);
    check("rm_coil",  32'(if0.stepmotor), 32'h0);
    check("rm_phase", 32'(if0.phase), 32'd0);
    check("rm_busy",  32'(if0.busy), 32'd0);
    check("rm_done",  32'(if0.done), 32'd0);
    tick();
    check("rm_nostart", 32'(if0.state), 32'd0);
    rst = 1'b1; start = 1'b0;
    tick();

    // ---- no-hold instance, start+stop together in IDLE
    mode = 2'b00; dir = 1'b1; period = 16'd0; steps = 12'd2; start = 1'b1; stop = 1'b1;
    tick(); start = 1'b0; stop = 1'b0;
    check("nh_state", 32'(if1.state), 32'd1);
    check("nh_busy",  32'(if1.busy), 32'd1);
    check("nh_coil0", 32'(if1.stepmotor), 32'h8);
    tick();
    check("nh_coil1", 32'(if1.stepmotor), 32'h4);
    tick();
    check("nh_coil2", 32'(if1.stepmotor), 32'h2);
    check("nh_done",  32'(if1.done), 32'd1);
    tick();
    check("nh_idle",  32'(if1.stepmotor), 32'h0);
    check("nh_phase", 32'(if1.phase), 32'd4);
    check("h_idle",   32'(if0.stepmotor), 32'h2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
